// File: rtl/wb_regfile_if.sv
// Write-back and register-read signal bundle between the MEM/WB/ID pipeline logic and the register file.
// The master side drives the write-back and read addresses; the slave side returns the read data, bypass value and counters.
interface wb_regfile_if;
  logic        RegWrite__i;
  logic        MemToReg__i;
  logic [31:0] MemReadData__i;
  logic [31:0] ALUData__i;
  logic [4:0]  WBReg__i;
  logic [4:0]  RsAddr__i;
  logic [4:0]  RtAddr__i;
  logic [31:0] RsData__o;
  logic [31:0] RtData__o;
  logic [31:0] WBData__o;
  logic        WBValid__o;
  logic [31:0] RetireCount__o;

  modport master (
    output RegWrite__i, MemToReg__i, MemReadData__i, ALUData__i,
           WBReg__i, RsAddr__i, RtAddr__i,
    input  RsData__o, RtData__o, WBData__o, WBValid__o, RetireCount__o
  );

  modport slave (
    input  RegWrite__i, MemToReg__i, MemReadData__i, ALUData__i,
           WBReg__i, RsAddr__i, RtAddr__i,
    output RsData__o, RtData__o, WBData__o, WBValid__o, RetireCount__o
  );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 register file with write-back mux, same-cycle write-through bypass on both read ports,
// and a wrapping count of committed writes; reads are combinational, writes land on the next edge.
module wb_regfile (
  input  logic       clock__i,
  input  logic       reset__i,
  wb_regfile_if.slave bus
);
  logic [31:0] regs [0:31];
  logic [31:0] retire_cnt;
  logic [31:0] wb_data;
  logic        wb_valid;

  assign wb_data  = bus.MemToReg__i ? bus.MemReadData__i : bus.ALUData__i;
  assign wb_valid = bus.RegWrite__i & (bus.WBReg__i != 5'd0) & ~reset__i;

  assign bus.WBData__o      = wb_data;
  assign bus.WBValid__o     = wb_valid;
  assign bus.RetireCount__o = retire_cnt;

  // wb_valid already excludes reset and r0, so a bypass hit never returns data for r0.
  always_comb begin
    if (wb_valid && (bus.RsAddr__i == bus.WBReg__i))
      bus.RsData__o = wb_data;
    else
      bus.RsData__o = regs[bus.RsAddr__i];

    if (wb_valid && (bus.RtAddr__i == bus.WBReg__i))
      bus.RtData__o = wb_data;
    else
      bus.RtData__o = regs[bus.RtAddr__i];
  end

  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h0;
      retire_cnt <= 32'h0;
    end else if (wb_valid) begin
      regs[bus.WBReg__i] <= wb_data;
      retire_cnt         <= retire_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed test of wb_regfile: write/read, bypass, r0, disabled write, counter wrap, reset collision.
module tb_wb_regfile;
  logic clock__i;
  logic reset__i;
  int   checks;
  int   errors;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock__i (clock__i),
    .reset__i (reset__i),
    .bus      (bus)
  );

  initial clock__i = 1'b0;
  always #5 clock__i = ~clock__i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return to the following falling edge.
  task automatic tick();
    @(posedge clock__i);
    @(negedge clock__i);
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.RegWrite__i    = we;
    bus.MemToReg__i    = m2r;
    bus.MemReadData__i = mem;
    bus.ALUData__i     = alu;
    bus.WBReg__i       = wb;
    bus.RsAddr__i      = rs;
    bus.RtAddr__i      = rt;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset__i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clock__i);
    tick();
    tick();

    // Reset state
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
    chk("reset_count", bus.RetireCount__o, 32'h0);
    chk("reset_rs", bus.RsData__o, 32'h0);
    reset__i = 1'b0;

    // Write r5 from ALU path
    drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h1234_5678, 5'd5, 5'd1, 5'd2);
    chk("wbdata_alu", bus.WBData__o, 32'h1234_5678);
    chk("wbvalid_r5", {31'b0, bus.WBValid__o}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    chk("read_r5", bus.RsData__o, 32'h1234_5678);
    chk("count_1", bus.RetireCount__o, 32'h1);
    chk("read_r0_rt", bus.RtData__o, 32'h0);

    // Same-cycle bypass of r7 from memory path on both ports
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7, 5'd7, 5'd7);
    chk("bypass_rs", bus.RsData__o, 32'hDEAD_BEEF);
    chk("bypass_rt", bus.RtData__o, 32'hDEAD_BEEF);
    chk("wbdata_mem", bus.WBData__o, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);
    chk("array_r7", bus.RsData__o, 32'hDEAD_BEEF);
    chk("array_r5", bus.RtData__o, 32'h1234_5678);
    chk("count_2", bus.RetireCount__o, 32'h2);

    // Write to r0 is dropped
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("r0_wbvalid", {31'b0, bus.WBValid__o}, 32'h0);
    chk("r0_bypass", bus.RsData__o, 32'h0);
    chk("r0_wbdata", bus.WBData__o, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_read", bus.RsData__o, 32'h0);
    chk("r0_count", bus.RetireCount__o, 32'h2);

    // Disabled write: r9 keeps prior value, no bypass
    drive(1'b1, 1'b0, 32'h0, 32'h0000_900D, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0055, 5'd9, 5'd9, 5'd9);
    chk("dis_wbvalid", {31'b0, bus.WBValid__o}, 32'h0);
    chk("dis_nobypass", bus.RsData__o, 32'h0000_900D);
    tick();
    chk("dis_keep", bus.RtData__o, 32'h0000_900D);
    chk("dis_count", bus.RetireCount__o, 32'h3);

    // Counter wrap from a preloaded value
    dut.retire_cnt <= 32'hFFFF_FFFE;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd1, 5'd1, 5'd0);
    chk("wrap_preload", bus.RetireCount__o, 32'hFFFF_FFFE);
    tick();
    chk("wrap_ffff", bus.RetireCount__o, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0002, 5'd2, 5'd1, 5'd2);
    chk("wrap_r1", bus.RsData__o, 32'h0000_0001);
    tick();
    chk("wrap_zero", bus.RetireCount__o, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0004, 5'd4, 5'd2, 5'd0);
    chk("wrap_r2", bus.RsData__o, 32'h0000_0002);
    tick();
    chk("count_after_wrap", bus.RetireCount__o, 32'h1);

    // Write collides with reset; bypass is disabled during reset
    reset__i = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'hAAAA_AAAA, 5'd3, 5'd3, 5'd5);
    chk("rst_wbvalid", {31'b0, bus.WBValid__o}, 32'h0);
    chk("rst_nobypass", bus.RsData__o, 32'h0);
    chk("rst_array_r5", bus.RtData__o, 32'h1234_5678);
    tick();
    reset__i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);
    chk("rst_r3", bus.RsData__o, 32'h0);
    chk("rst_r5", bus.RtData__o, 32'h0);
    chk("rst_count", bus.RetireCount__o, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd9);
    chk("rst_r7", bus.RsData__o, 32'h0);
    chk("rst_r9", bus.RtData__o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
